// File: rtl/instr_fetch.sv
// Instruction fetch stage: one AXI4-Lite-style read per accepted request, with
// misaligned/bus-error reporting and a discard flag so an in-flight fetch can be flushed.
//
// state | meaning
// IDLE  | no transaction; accepts fetch_start, reports misaligned pc
// ADDR  | read address presented, waiting for mem_arready
// DATA  | waiting for mem_rvalid; response kept or discarded
module instr_fetch #(
    parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc,
    input  logic        fetch_start,
    input  logic        flush,
    output logic        mem_arvalid,
    output logic [31:0] mem_araddr,
    input  logic        mem_arready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    output logic        mem_rready,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic        instr_valid,
    output logic        fetch_err,
    output logic [1:0]  err_cause,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t      state, state_nxt;
    logic        discard, discard_nxt;
    logic [31:0] araddr_nxt;
    logic [31:0] instr_nxt;
    logic        valid_nxt;
    logic        err_nxt;
    logic [1:0]  cause_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            discard     <= 1'b0;
            mem_araddr  <= 32'h0;
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b0;
            busy        <= 1'b0;
            instr       <= RESET_INSTR;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            err_cause   <= 2'b00;
        end else begin
            state       <= state_nxt;
            discard     <= discard_nxt;
            mem_araddr  <= araddr_nxt;
            mem_arvalid <= (state_nxt == S_ADDR);
            mem_rready  <= (state_nxt == S_DATA);
            busy        <= (state_nxt != S_IDLE);
            instr       <= instr_nxt;
            instr_valid <= valid_nxt;
            fetch_err   <= err_nxt;
            err_cause   <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        araddr_nxt  = mem_araddr;
        instr_nxt   = instr;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        cause_nxt   = err_cause;
        case (state)
            S_IDLE: begin
                // flush wins over a simultaneous request
                if (fetch_start && !flush) begin
                    if (pc[1:0] == 2'b00) begin
                        araddr_nxt  = pc;
                        discard_nxt = 1'b0;
                        state_nxt   = S_ADDR;
                    end else begin
                        err_nxt   = 1'b1;
                        cause_nxt = 2'b01;
                    end
                end
            end
            S_ADDR: begin
                if (flush) discard_nxt = 1'b1;
                if (mem_arready) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (flush) discard_nxt = 1'b1;
                if (mem_rvalid) begin
                    state_nxt = S_IDLE;
                    // a flush landing on the handshake cycle still discards this beat
                    if (!(discard || flush)) begin
                        if (mem_rresp == 2'b00) begin
                            instr_nxt = mem_rdata;
                            valid_nxt = 1'b1;
                        end else begin
                            err_nxt   = 1'b1;
                            cause_nxt = 2'b10;
                        end
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign opcode = instr[6:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed test-plan cases plus randomized fetches; a
// scoreboard queue of expected pulses is drained by an independent monitor.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam int K_VALID = 0;
    localparam int K_ERR   = 1;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        fetch_start = 1'b0;
    logic        flush = 1'b0;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic        mem_arready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [1:0]  mem_rresp = 2'b00;
    logic        mem_rready;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic        instr_valid;
    logic        fetch_err;
    logic [1:0]  err_cause;
    logic        busy;

    instr_fetch dut (
        .clk(clk), .rstn(rstn), .pc(pc), .fetch_start(fetch_start), .flush(flush),
        .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
        .mem_rready(mem_rready), .instr(instr), .opcode(opcode),
        .instr_valid(instr_valid), .fetch_err(fetch_err), .err_cause(err_cause), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] word;
        logic [1:0]  cause;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_instr = NOP;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rstn && (instr_valid || fetch_err)) begin
            chk("pulse_exclusive", {31'b0, instr_valid && fetch_err}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'b0, instr_valid, fetch_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.kind == K_VALID) begin
                    chk("sb_instr_valid", {31'b0, instr_valid}, 32'd1);
                    chk("sb_instr", instr, e.word);
                    chk("sb_opcode", {25'b0, opcode}, {25'b0, e.word[6:0]});
                end else begin
                    chk("sb_fetch_err", {31'b0, fetch_err}, 32'd1);
                    chk("sb_err_cause", {30'b0, err_cause}, {30'b0, e.cause});
                end
            end
        end
    end

    // fph: 0 none, 1 flush with start in IDLE, 2 flush in ADDR, 3 flush while waiting in DATA,
    // 4 flush on the data-handshake cycle. Called and returns just after a falling edge.
    task automatic do_fetch(input logic [31:0] p, input int ard, input int rd,
                            input logic [31:0] rdat, input logic [1:0] rr, input int fph);
        exp_t e;
        bit   mis;
        bit   disc;
        mis  = (p[1:0] != 2'b00);
        disc = (fph != 0);
        if (fph != 1) begin
            if (mis) begin
                e.kind = K_ERR; e.word = 32'h0; e.cause = 2'b01; sb.push_back(e);
            end else if (!disc) begin
                if (rr == 2'b00) begin
                    e.kind = K_VALID; e.word = rdat; e.cause = 2'b00; exp_instr = rdat;
                end else begin
                    e.kind = K_ERR; e.word = 32'h0; e.cause = 2'b10;
                end
                sb.push_back(e);
            end
        end
        pc = p; fetch_start = 1'b1; flush = (fph == 1);
        tick();
        fetch_start = 1'b0; flush = 1'b0; pc = $urandom;
        if (fph == 1) begin
            chk("idle_flush_busy", {31'b0, busy}, 32'd0);
            chk("idle_flush_arvalid", {31'b0, mem_arvalid}, 32'd0);
            chk("idle_flush_err", {31'b0, fetch_err}, 32'd0);
            return;
        end
        if (mis) begin
            chk("mis_err_next", {31'b0, fetch_err}, 32'd1);
            chk("mis_cause", {30'b0, err_cause}, 32'd1);
            chk("mis_busy", {31'b0, busy}, 32'd0);
            chk("mis_arvalid", {31'b0, mem_arvalid}, 32'd0);
            return;
        end
        chk("addr_arvalid", {31'b0, mem_arvalid}, 32'd1);
        chk("addr_busy", {31'b0, busy}, 32'd1);
        chk("addr_araddr", mem_araddr, p);
        for (int i = 0; i < ard; i++) begin
            mem_arready = 1'b0;
            flush = (fph == 2 && i == 0);
            tick();
            flush = 1'b0;
            chk("stall_arvalid", {31'b0, mem_arvalid}, 32'd1);
            chk("stall_araddr", mem_araddr, p);
        end
        mem_arready = 1'b1;
        flush = (fph == 2 && ard == 0);
        tick();
        mem_arready = 1'b0; flush = 1'b0;
        chk("data_arvalid_low", {31'b0, mem_arvalid}, 32'd0);
        chk("data_rready", {31'b0, mem_rready}, 32'd1);
        for (int i = 0; i < rd; i++) begin
            flush = (fph == 3 && i == 0);
            tick();
            flush = 1'b0;
            chk("wait_rready", {31'b0, mem_rready}, 32'd1);
            chk("wait_busy", {31'b0, busy}, 32'd1);
        end
        mem_rvalid = 1'b1; mem_rdata = rdat; mem_rresp = rr;
        flush = (fph == 4) || (fph == 3 && rd == 0);
        tick();
        mem_rvalid = 1'b0; flush = 1'b0; mem_rdata = $urandom; mem_rresp = 2'($urandom);
        chk("resp_instr_valid", {31'b0, instr_valid}, {31'b0, !disc && rr == 2'b00});
        chk("resp_fetch_err", {31'b0, fetch_err}, {31'b0, !disc && rr != 2'b00});
        chk("resp_busy", {31'b0, busy}, 32'd0);
        chk("resp_rready", {31'b0, mem_rready}, 32'd0);
        chk("held_instr", instr, exp_instr);
        if (!disc && rr != 2'b00) chk("bus_err_cause", {30'b0, err_cause}, 32'd2);
    endtask

    task automatic chk_reset_vals();
        chk("rst_arvalid", {31'b0, mem_arvalid}, 32'd0);
        chk("rst_rready", {31'b0, mem_rready}, 32'd0);
        chk("rst_araddr", mem_araddr, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_opcode", {25'b0, opcode}, 32'h13);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_err_cause", {30'b0, err_cause}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nrand;
        repeat (2) tick();
        chk_reset_vals();
        rstn = 1'b1;
        tick();

        // zero-wait fetch: instr_valid 3 cycles after the start cycle
        do_fetch(32'h00000100, 0, 0, 32'h00500093, 2'b00, 0);
        chk("zw_opcode", {25'b0, opcode}, 32'h13);
        // stalls
        do_fetch(32'h00000104, 4, 5, 32'h12345678, 2'b00, 0);
        // faults
        do_fetch(32'h00000102, 0, 0, 32'h0, 2'b00, 0);
        do_fetch(32'h00000108, 1, 1, 32'hDEADBEEF, 2'b10, 0);
        // flushes
        do_fetch(32'h0000010C, 2, 1, 32'hCAFEF00D, 2'b00, 2);
        do_fetch(32'h00000110, 0, 2, 32'hFEEDFACE, 2'b00, 4);
        do_fetch(32'h00000114, 0, 0, 32'hABCDEF01, 2'b00, 1);
        // back-to-back, one fetch every 3 cycles
        do_fetch(32'h00000000, 0, 0, 32'h00100113, 2'b00, 0);
        do_fetch(32'h00000004, 0, 0, 32'h00200193, 2'b00, 0);
        do_fetch(32'h00000008, 0, 0, 32'h00300213, 2'b00, 0);

        for (nrand = 0; nrand < 200; nrand++) begin
            logic [31:0] p;
            logic [1:0]  rr;
            int          fph;
            p = $urandom & 32'h0000FFFC;
            if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
            rr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            fph = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            do_fetch(p, $urandom_range(0, 4), $urandom_range(0, 5), $urandom, rr, fph);
            if ($urandom_range(0, 3) == 0) tick();
        end

        // reset in mid-DATA drops the transaction and restores reset values
        do_fetch(32'h00000200, 0, 0, 32'h00A00513, 2'b00, 0);
        pc = 32'h00000204; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0; mem_arready = 1'b1;
        tick();
        mem_arready = 1'b0;
        chk("pre_rst_in_data", {31'b0, mem_rready}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk_reset_vals();
        tick();
        rstn = 1'b1;
        exp_instr = NOP;
        tick();
        chk_reset_vals();
        do_fetch(32'h00000300, 0, 0, 32'h00C00613, 2'b00, 0);

        repeat (3) tick();
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
